alu_cmd_sequencer: RTL and testbench

- Command front-end that drives the ALU from a byte stream, typically the UART receiver.
- Collects three bytes in order: operand A, operand B, opcode. It then presents them to the ALU, captures the result and hands it to the UART transmitter as one byte.
- Sits between uart_rx/uart_tx and the ALU, acting as the initiator for the ALU's operand/opcode interface.

---
 rtl/alu_cmd_sequencer.sv | 148 ++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// Byte-stream command front-end: collects operand A, operand B and opcode, runs the ALU and sends the result.
// Optional macro ALU_SEQ_STATUS_BYTE_EN appends a {carry, zero} status byte after each result byte.
module alu_cmd_sequencer #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP_CODE     = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [NB_DATA-1:0]    i_rx_data,
    input  logic                  i_rx_done,
    output logic [NB_DATA-1:0]    o_data_a,
    output logic [NB_DATA-1:0]    o_data_b,
    output logic [NB_OP_CODE-1:0] o_op_code,
    input  logic [NB_DATA-1:0]    i_alu_result,
    input  logic                  i_alu_zero,
    input  logic                  i_alu_carry,
    output logic [NB_DATA-1:0]    o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_rx_drop
);

    localparam int NB_CNT = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        WAIT_A   = 3'd0,
        WAIT_B   = 3'd1,
        WAIT_OP  = 3'd2,
        EXEC     = 3'd3,
        SEND     = 3'd4,
        WAIT_TX  = 3'd5,
        SEND_STS = 3'd6,
        WAIT_STS = 3'd7
    } state_t;

    state_t                  state_reg, state_next;
    logic [NB_CNT-1:0]       cnt_reg, cnt_next;
    logic [NB_DATA-1:0]      data_a_reg, data_b_reg, tx_data_reg;
    logic [NB_OP_CODE-1:0]   op_code_reg;
    logic                    rx_drop_reg;
    logic                    accepting;

    assign accepting = (state_reg == WAIT_A) || (state_reg == WAIT_B) || (state_reg == WAIT_OP);

    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        o_tx_start = 1'b0;
        o_busy     = 1'b0;
        case (state_reg)
            WAIT_A: begin
                if (i_rx_done) state_next = WAIT_B;
            end
            WAIT_B, WAIT_OP: begin
                // An arriving byte always beats an expiring timeout.
                if (i_rx_done)
                    state_next = (state_reg == WAIT_B) ? WAIT_OP : EXEC;
                else if (cnt_reg == CNT_LAST)
                    state_next = WAIT_A;
                else
                    cnt_next = cnt_reg + 1'b1;
            end
            EXEC: begin
                o_busy     = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_next = WAIT_TX;
            end
            WAIT_TX: begin
                o_busy = 1'b1;
                if (i_tx_done) begin
`ifdef ALU_SEQ_STATUS_BYTE_EN
                    state_next = SEND_STS;
`else
                    state_next = WAIT_A;
`endif
                end
            end
`ifdef ALU_SEQ_STATUS_BYTE_EN
            SEND_STS: begin
                o_busy     = 1'b1;
                o_tx_start = 1'b1;
                state_next = WAIT_STS;
            end
            WAIT_STS: begin
                o_busy = 1'b1;
                if (i_tx_done) state_next = WAIT_A;
            end
`endif
            default: state_next = WAIT_A;
        endcase
    end

`ifdef ALU_SEQ_STATUS_BYTE_EN
    logic [1:0] flags_reg;
`else
    logic unused_flags;
    assign unused_flags = i_alu_zero ^ i_alu_carry;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg   <= WAIT_A;
            cnt_reg     <= '0;
            data_a_reg  <= '0;
            data_b_reg  <= '0;
            op_code_reg <= '0;
            tx_data_reg <= '0;
            rx_drop_reg <= 1'b0;
`ifdef ALU_SEQ_STATUS_BYTE_EN
            flags_reg   <= 2'b00;
`endif
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            rx_drop_reg <= i_rx_done && !accepting;
            case (state_reg)
                WAIT_A:  if (i_rx_done) data_a_reg  <= i_rx_data;
                WAIT_B:  if (i_rx_done) data_b_reg  <= i_rx_data;
                WAIT_OP: if (i_rx_done) op_code_reg <= i_rx_data[NB_OP_CODE-1:0];
                EXEC: begin
                    tx_data_reg <= i_alu_result;
`ifdef ALU_SEQ_STATUS_BYTE_EN
                    flags_reg   <= {i_alu_carry, i_alu_zero};
`endif
                end
`ifdef ALU_SEQ_STATUS_BYTE_EN
                // Load the status byte ahead of SEND_STS so it is valid during the start pulse.
                WAIT_TX: if (i_tx_done) tx_data_reg <= {{(NB_DATA-2){1'b0}}, flags_reg};
`endif
                default: ;
            endcase
        end
    end

    assign o_data_a  = data_a_reg;
    assign o_data_b  = data_b_reg;
    assign o_op_code = op_code_reg;
    assign o_tx_data = tx_data_reg;
    assign o_rx_drop = rx_drop_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: vector table of commands plus timeout, drop and reset sequences.
module tb_alu_cmd_sequencer;

    localparam int NB_DATA = 8;
    localparam int NB_OP   = 6;
    localparam int TMO     = 16;

    logic             i_clock, i_reset;
    logic [7:0]       i_rx_data;
    logic             i_rx_done;
    logic [7:0]       o_data_a, o_data_b, o_tx_data;
    logic [5:0]       o_op_code;
    logic [7:0]       i_alu_result;
    logic             i_alu_zero, i_alu_carry;
    logic             o_tx_start, i_tx_done, o_busy, o_rx_drop;

    int total = 0;
    int bad   = 0;

    alu_cmd_sequencer #(.NB_DATA(NB_DATA), .NB_OP_CODE(NB_OP), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clock(i_clock), .i_reset(i_reset),
        .i_rx_data(i_rx_data), .i_rx_done(i_rx_done),
        .o_data_a(o_data_a), .o_data_b(o_data_b), .o_op_code(o_op_code),
        .i_alu_result(i_alu_result), .i_alu_zero(i_alu_zero), .i_alu_carry(i_alu_carry),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_busy(o_busy), .o_rx_drop(o_rx_drop)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Small ALU stand-in: carry is carry-out for ADD and borrow for SUB.
    logic [8:0] alu_wide;
    always_comb begin
        alu_wide = 9'd0;
        case (o_op_code)
            6'h20: alu_wide = {1'b0, o_data_a} + {1'b0, o_data_b};
            6'h22: alu_wide = {1'b0, o_data_a} - {1'b0, o_data_b};
            6'h24: alu_wide = {1'b0, o_data_a & o_data_b};
            6'h25: alu_wide = {1'b0, o_data_a | o_data_b};
            6'h26: alu_wide = {1'b0, o_data_a ^ o_data_b};
            default: alu_wide = 9'd0;
        endcase
        i_alu_result = alu_wide[7:0];
        i_alu_carry  = alu_wide[8];
        i_alu_zero   = (alu_wide[7:0] == 8'd0);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic rx(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(negedge i_clock);
        i_rx_done = 1'b0;
    endtask

    task automatic tx_done_pulse();
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
    endtask

    // Feeds a full command and stops in WAIT_TX with the result byte on o_tx_data.
    task automatic cmd_to_wait_tx(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op,
                                  input logic [5:0] exp_op, input logic [7:0] exp_tx);
        rx(a); rx(b); rx(op);
        check("data_a", o_data_a, a);
        check("data_b", o_data_b, b);
        check("op_code", o_op_code, exp_op);
        check("start_exec", o_tx_start, 1'b0);
        check("busy_exec", o_busy, 1'b1);
        @(negedge i_clock);
        check("start_send", o_tx_start, 1'b1);
        check("tx_data", o_tx_data, exp_tx);
        @(negedge i_clock);
        check("start_wait", o_tx_start, 1'b0);
        check("busy_wait", o_busy, 1'b1);
        check("tx_hold", o_tx_data, exp_tx);
        $display("cmd a=%02h b=%02h op=%02h -> tx=%02h", a, b, op, o_tx_data);
    endtask

    task automatic finish_tx(input logic [7:0] exp_sts);
        tx_done_pulse();
`ifdef ALU_SEQ_STATUS_BYTE_EN
        check("start_sts", o_tx_start, 1'b1);
        check("tx_sts", o_tx_data, exp_sts);
        check("busy_sts", o_busy, 1'b1);
        @(negedge i_clock);
        check("start_sts_end", o_tx_start, 1'b0);
        tx_done_pulse();
`else
        if (exp_sts === 8'hxx) $display("unreachable");
`endif
        check("busy_idle", o_busy, 1'b0);
        check("start_idle", o_tx_start, 1'b0);
    endtask

    typedef struct {
        logic [7:0] a, b, op;
        logic [5:0] exp_op;
        logic [7:0] exp_tx;
        logic [7:0] exp_sts;
    } vec_t;

    vec_t vecs[7];

    initial begin
        vecs[0] = '{8'h05, 8'h03, 8'h20, 6'h20, 8'h08, 8'h00};
        vecs[1] = '{8'h03, 8'h05, 8'hE2, 6'h22, 8'hFE, 8'h02};
        vecs[2] = '{8'hFF, 8'h01, 8'h20, 6'h20, 8'h00, 8'h03};
        vecs[3] = '{8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF, 8'h00};
        vecs[4] = '{8'h01, 8'h01, 8'h64, 6'h24, 8'h01, 8'h00};
        vecs[5] = '{8'hAA, 8'h55, 8'h26, 6'h26, 8'hFF, 8'h00};
        vecs[6] = '{8'h3C, 8'h3C, 8'hA6, 6'h26, 8'h00, 8'h01};

        i_reset = 1'b1; i_rx_data = 8'h00; i_rx_done = 1'b0; i_tx_done = 1'b0;
        repeat (3) @(negedge i_clock);
        check("rst_a", o_data_a, 8'h00);
        check("rst_b", o_data_b, 8'h00);
        check("rst_op", o_op_code, 6'h00);
        check("rst_tx", o_tx_data, 8'h00);
        check("rst_flags", {o_tx_start, o_busy, o_rx_drop}, 3'b000);
        i_reset = 1'b0;
        @(negedge i_clock);

        // Stray tx_done while idle must be ignored.
        tx_done_pulse();
        check("stray_done_busy", o_busy, 1'b0);

        for (int i = 0; i < 7; i++) begin
            cmd_to_wait_tx(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp_op, vecs[i].exp_tx);
            finish_tx(vecs[i].exp_sts);
        end

        // Timeout: partial command abandoned after TMO idle cycles.
        rx(8'h11); rx(8'h22);
        repeat (TMO) @(negedge i_clock);
        check("tmo_busy", o_busy, 1'b0);
        check("tmo_stale_a", o_data_a, 8'h11);
        cmd_to_wait_tx(8'h01, 8'h01, 8'h24, 6'h24, 8'h01);
        finish_tx(8'h00);

        // Byte arriving on the expiry cycle is accepted.
        rx(8'h11);
        repeat (TMO - 1) @(negedge i_clock);
        rx(8'h22);
        repeat (TMO - 1) @(negedge i_clock);
        rx(8'h20);
        check("edge_a", o_data_a, 8'h11);
        check("edge_b", o_data_b, 8'h22);
        check("edge_busy", o_busy, 1'b1);
        @(negedge i_clock);
        check("edge_start", o_tx_start, 1'b1);
        check("edge_tx", o_tx_data, 8'h33);
        @(negedge i_clock);
        $display("cmd timeout-edge -> tx=%02h", o_tx_data);
        finish_tx(8'h00);

        // Drop during transmit.
        cmd_to_wait_tx(8'h05, 8'h03, 8'h20, 6'h20, 8'h08);
        check("drop_idle", o_rx_drop, 1'b0);
        rx(8'h77);
        check("drop_pulse", o_rx_drop, 1'b1);
        check("drop_a_kept", o_data_a, 8'h05);
        @(negedge i_clock);
        check("drop_once", o_rx_drop, 1'b0);
        $display("drop 77 during WAIT_TX");
        finish_tx(8'h00);
        cmd_to_wait_tx(8'h10, 8'h20, 8'h20, 6'h20, 8'h30);
        finish_tx(8'h00);

        // Reset in WAIT_TX aborts the command without further pulses.
        cmd_to_wait_tx(8'h03, 8'h05, 8'h22, 6'h22, 8'hFE);
        i_reset = 1'b1;
        @(negedge i_clock);
        check("mid_rst_a", o_data_a, 8'h00);
        check("mid_rst_b", o_data_b, 8'h00);
        check("mid_rst_op", o_op_code, 6'h00);
        check("mid_rst_tx", o_tx_data, 8'h00);
        check("mid_rst_flags", {o_tx_start, o_busy, o_rx_drop}, 3'b000);
        i_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge i_clock);
            check("post_rst_start", o_tx_start, 1'b0);
        end
        $display("reset in WAIT_TX");
        cmd_to_wait_tx(8'h0F, 8'hF0, 8'h25, 6'h25, 8'hFF);
        finish_tx(8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
